// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   arb_state_e : sequencer states (IDLE -> ACCESS -> RESP -> IDLE)
//   PORT_CPU/PORT_DMA : port indices as used by owner/last_grant
//   misaligned() : word-alignment test on the two address LSBs
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner select between two requesters.
//   req0/req1  : live requests
//   last_grant : port granted most recently
//   any        : at least one request present
//   winner     : port to grant (only meaningful when any=1)
// FAIR!=0 alternates on a tie; FAIR==0 always favours the CPU port.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int FAIR = 1
) (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic any,
  output logic winner
);

  always_comb begin
    any    = req0 | req1;
    winner = PORT_CPU;
    if (req0 && req1) begin
      winner = (FAIR != 0) ? ~last_grant : PORT_CPU;
    end else if (req1) begin
      winner = PORT_DMA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for a single-port word memory
// (combinational read, write on posedge clk when mem_we=1).
//   clk, reset        : clock, async active-high reset
//   req/we/a/wd (x2)  : requests, held stable until the matching ack
//   ack/err/rd (x2)   : one-cycle completion, misalign flag, read data
//   mem_we/a/wd/rd    : memory interface
//   busy, owner       : sequencer active, currently/last granted port
// Every access takes IDLE -> ACCESS -> RESP, so one access per 3 cycles.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FAIR  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             we0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] wd0,
  output logic             ack0,
  output logic             err0,
  output logic [WIDTH-1:0] rd0,
  input  logic             req1,
  input  logic             we1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] wd1,
  output logic             ack1,
  output logic             err1,
  output logic [WIDTH-1:0] rd1,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_a,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd,
  output logic             busy,
  output logic             owner
);

  arb_state_e       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic             we_q, we_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] wd_q, wd_d;
  logic [WIDTH-1:0] rd_q, rd_d;

  logic             any;
  logic             winner;
  logic             we_sel;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] wd_sel;

  rr_pick #(.FAIR(FAIR)) u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .any        (any),
    .winner     (winner)
  );

  assign we_sel = winner ? we1 : we0;
  assign a_sel  = winner ? a1  : a0;
  assign wd_sel = winner ? wd1 : wd0;

  // Next state. Live request inputs are only looked at in IDLE; after the
  // grant everything runs from the latched copies.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_d         = we_q;
    err_d        = err_q;
    a_d          = a_q;
    wd_d         = wd_q;
    rd_d         = rd_q;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          owner_d      = winner;
          last_grant_d = winner;
          we_d         = we_sel;
          a_d          = a_sel;
          wd_d         = wd_sel;
          err_d        = misaligned(a_sel[1:0]);
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        // rd_q holds its old value on writes and rejected reads.
        if (!we_q && !err_q) rd_d = mem_rd;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_DMA;  // so the CPU wins the first tie
      owner_q      <= PORT_CPU;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      a_q          <= '0;
      wd_q         <= '0;
      rd_q         <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      err_q        <= err_d;
      a_q          <= a_d;
      wd_q         <= wd_d;
      rd_q         <= rd_d;
    end
  end

  // Outputs decode from registers only; since state_q clears asynchronously,
  // mem_we drops the moment reset is asserted.
  assign mem_we = (state_q == ACCESS) && we_q && !err_q;
  assign mem_a  = a_q;
  assign mem_wd = wd_q;
  assign ack0   = (state_q == RESP) && (owner_q == PORT_CPU);
  assign ack1   = (state_q == RESP) && (owner_q == PORT_DMA);
  assign err0   = ack0 && err_q;
  assign err1   = ack1 && err_q;
  assign rd0    = rd_q;
  assign rd1    = rd_q;
  assign busy   = (state_q != IDLE);
  assign owner  = owner_q;

endmodule
